// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared fetch-path widths, queue depth default and the queued fetch entry layout
package rv32i_pkg;
  localparam int DEF_XLEN = 64;
  localparam int DEF_ILEN = 32;
  localparam int FETCH_DEPTH = 4;
  localparam int INSTR_BYTES = DEF_ILEN / 8;
  typedef struct packed {
    logic [DEF_XLEN-1:0] pc;
    logic [DEF_ILEN-1:0] instr;
    logic                misalign;
  } fetch_entry_t;
endpackage

// File: rtl/rv32i_sync_fifo.sv
// rv32i_sync_fifo: synchronous FIFO with flush and occupancy count
// Ports: clk/rst (sync, active-high); push/din write; pop reads dout (head); flush empties; count occupancy.
module rv32i_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  input  logic                         flush,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic do_pop;
  always_comb begin
    do_pop = pop && count_q != '0;
    wr_d = flush ? '0 : push ? wr_q + AW'(1) : wr_q;
    rd_d = flush ? '0 : do_pop ? rd_q + AW'(1) : rd_q;
    count_d = flush ? '0 : count_q + CW'(push) - CW'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end
  assign dout = mem_q[rd_q];
  assign count = count_q;
endmodule

// File: rtl/rv32i_fetch_queue.sv
// rv32i_fetch_queue: instruction fetch unit with prefetch queue, redirect flush and stale-response discard
// Ports: clk/rst (sync, active-high); redirect_valid/redirect_pc load a new PC and flush the queue;
//   imem_req_valid/ready/addr fetch request; imem_rsp_valid/data in-order responses;
//   instr_valid/ready/data/pc head entry to decode; instr_misalign only with FETCH_MISALIGN_TRAP_EN.
// FETCH_MISALIGN_TRAP_EN: a misaligned redirect queues one trap marker and stalls fetch until the next
//   redirect; without it the redirect target is force-aligned.
module rv32i_fetch_queue
  import rv32i_pkg::*;
#(
  parameter int              XLEN     = DEF_XLEN,
  parameter int              ILEN     = DEF_ILEN,
  parameter int              IALIGN   = 32,
  parameter int              DEPTH    = FETCH_DEPTH,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instr_data,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_misalign
`else
  output logic [XLEN-1:0] instr_pc
`endif
);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [XLEN-1:0] STEP = XLEN'(ILEN/8);
  localparam logic [XLEN-1:0] AMASK = XLEN'(IALIGN/8 - 1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
  logic [XLEN-1:0] req_pc_q, req_pc_d, rsp_pc_q, rsp_pc_d, tgt;
  logic [CW-1:0] inflight_q, inflight_d, discard_q, discard_d, count;
  logic fire, pop, push, rsp_use, marker, stall;
  fetch_entry_t push_entry, head;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic stall_q, stall_d, pend_q, pend_d, bad_pc;
  assign bad_pc = |(redirect_pc & AMASK);
  assign tgt = redirect_pc;
  // marker waits until every stale response has come back so it lands after them in order
  assign marker = pend_q && inflight_q == '0 && !redirect_valid;
  assign stall = stall_q;
  assign instr_misalign = instr_valid && head.misalign;
  always_comb begin
    stall_d = redirect_valid ? bad_pc : stall_q;
    pend_d = redirect_valid ? bad_pc : pend_q && !marker;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      stall_q <= stall_d;
      pend_q <= pend_d;
    end
  end
`else
  logic unused_misalign;
  assign tgt = redirect_pc & ~AMASK;
  assign marker = 1'b0;
  assign stall = 1'b0;
  assign unused_misalign = head.misalign;
`endif
  // outstanding requests reserve queue slots, so a response push can never overflow
  assign imem_req_valid = !rst && !redirect_valid && !stall && ({1'b0, count} + {1'b0, inflight_q} < DEPTH_W);
  assign imem_req_addr = req_pc_q;
  assign instr_valid = count != '0;
  assign instr_data = instr_valid ? head.instr : '0;
  assign instr_pc = instr_valid ? head.pc : '0;
  always_comb begin
    fire = imem_req_valid && imem_req_ready;
    pop = instr_valid && instr_ready;
    inflight_d = inflight_q + CW'(fire) - CW'(imem_rsp_valid);
    rsp_use = imem_rsp_valid && discard_q == '0 && !redirect_valid;
    push = rsp_use || marker;
    push_entry = marker ? fetch_entry_t'{pc: req_pc_q, instr: '0, misalign: 1'b1}
                        : fetch_entry_t'{pc: rsp_pc_q, instr: imem_rsp_data, misalign: 1'b0};
    // on redirect everything still outstanding after this cycle's response is stale
    discard_d = redirect_valid ? inflight_d
              : (imem_rsp_valid && discard_q != '0) ? discard_q - CW'(1) : discard_q;
    req_pc_d = redirect_valid ? tgt : fire ? req_pc_q + STEP : req_pc_q;
    rsp_pc_d = redirect_valid ? tgt : rsp_use ? rsp_pc_q + STEP : rsp_pc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      req_pc_q <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      inflight_q <= '0;
      discard_q <= '0;
    end else begin
      req_pc_q <= req_pc_d;
      rsp_pc_q <= rsp_pc_d;
      inflight_q <= inflight_d;
      discard_q <= discard_d;
    end
  end
  rv32i_sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din(push_entry),
    .pop(pop),
    .flush(redirect_valid),
    .dout(head),
    .count(count)
  );
endmodule

// File: tb/tb_rv32i_fetch_queue.sv
// tb_rv32i_fetch_queue: directed self-checking bench with an in-order variable-latency memory model
module tb_rv32i_fetch_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic imem_req_valid, imem_req_ready = 1'b1;
  logic [63:0] imem_req_addr;
  logic imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic instr_valid, instr_ready = 1'b1;
  logic [31:0] instr_data;
  logic [63:0] instr_pc;
  logic instr_misalign;
  int errors = 0, checks = 0, fires = 0, lat = 1, cyc = 0;
  typedef struct {logic [63:0] a; int due;} mreq_t;
  mreq_t mq[$];
  logic [63:0] lpc[$];
  logic [31:0] ldat[$];
  logic lmis[$];

  rv32i_fetch_queue dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
`ifdef FETCH_MISALIGN_TRAP_EN
    .instr_pc(instr_pc), .instr_misalign(instr_misalign)
`else
    .instr_pc(instr_pc)
`endif
  );
`ifndef FETCH_MISALIGN_TRAP_EN
  assign instr_misalign = 1'b0;
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [63:0] a);
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  always @(negedge clk) begin
    if (imem_req_valid && imem_req_ready) begin
      mq.push_back('{imem_req_addr, cyc + lat});
      fires++;
    end
    if (instr_valid && instr_ready) begin
      lpc.push_back(instr_pc);
      ldat.push_back(instr_data);
      lmis.push_back(instr_misalign);
    end
  end

  always @(posedge clk) begin
    logic r;
    r = rst;
    cyc++;
    #1;
    if (r) begin
      mq.delete();
      imem_rsp_valid = 1'b0;
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data = word(mq[0].a);
      void'(mq.pop_front());
    end else imem_rsp_valid = 1'b0;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_log();
    lpc.delete();
    ldat.delete();
    lmis.delete();
  endtask

  task automatic redirect(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [63:0] p;
    bit hit;
    tick();
    tick();
    check("rst_req_valid", 64'(imem_req_valid), 0);
    check("rst_instr_valid", 64'(instr_valid), 0);
    check("rst_instr_data", 64'(instr_data), 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_misalign", 64'(instr_misalign), 0);
    rst = 1'b0;
    #1;
    check("t1_req_valid", 64'(imem_req_valid), 1);
    check("t1_req_addr", imem_req_addr, 0);
    clear_log();
    repeat (12) tick();
    check("t1_rate", 64'(lpc.size() >= 8), 1);
    for (int i = 0; i < 8; i++) begin
      check("t1_pc", lpc[i], 64'(4 * i));
      check("t1_data", 64'(ldat[i]), 64'(word(64'(4 * i))));
    end

    instr_ready = 1'b0;
    redirect(64'h40);
    fires = 0;
    repeat (10) tick();
    check("t2_fires", 64'(fires), 4);
    check("t2_req_valid", 64'(imem_req_valid), 0);
    check("t2_instr_valid", 64'(instr_valid), 1);
    check("t2_head_pc", instr_pc, 64'h40);
    check("t2_head_data", 64'(instr_data), 64'hC0DE0040);
    clear_log();
    instr_ready = 1'b1;
    repeat (8) tick();
    for (int i = 0; i < 5; i++) begin
      check("t2_drain_pc", lpc[i], 64'h40 + 64'(4 * i));
      check("t2_drain_data", 64'(ldat[i]), 64'(word(64'h40 + 64'(4 * i))));
    end

    imem_req_ready = 1'b0;
    repeat (8) tick();
    lat = 3;
    fires = 0;
    imem_req_ready = 1'b1;
    repeat (3) tick();
    check("t3_inflight", 64'(fires), 3);
    imem_req_ready = 1'b0;
    clear_log();
    redirect(64'h100);
    imem_req_ready = 1'b1;
    repeat (12) tick();
    check("t3_first_pc", lpc[0], 64'h100);
    check("t3_first_data", 64'(ldat[0]), 64'hC0DE0100);
    check("t3_second_pc", lpc[1], 64'h104);

    lat = 2;
    repeat (8) tick();
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (imem_rsp_valid && instr_valid) hit = 1'b1;
      else tick();
    end
    check("t4_found", 64'(hit), 1);
    n = lpc.size();
    check("t4_prelog", 64'(n > 0), 1);
    p = n > 0 ? lpc[n-1] : '0;
    redirect_valid = 1'b1;
    redirect_pc = 64'h200;
    #1;
    check("t4_no_req", 64'(imem_req_valid), 0);
    tick();
    redirect_valid = 1'b0;
    check("t4_pop_done", 64'(lpc.size()), 64'(n + 1));
    check("t4_pop_pc", lpc[n], p + 64'd4);
    clear_log();
    repeat (10) tick();
    check("t4_next_pc", lpc[0], 64'h200);
    check("t4_next_data", 64'(ldat[0]), 64'hC0DE0200);
    check("t4_then_pc", lpc[1], 64'h204);

    lat = 1;
    repeat (4) tick();
    redirect(64'h102);
    clear_log();
`ifdef FETCH_MISALIGN_TRAP_EN
    fires = 0;
    #1;
    check("t5_stall_valid", 64'(imem_req_valid), 0);
    repeat (8) tick();
    check("t5_no_fetch", 64'(fires), 0);
    check("t5_one_entry", 64'(lpc.size()), 1);
    check("t5_marker_pc", lpc[0], 64'h102);
    check("t5_marker_mis", 64'(lmis[0]), 1);
    check("t5_marker_data", 64'(ldat[0]), 0);
    redirect(64'h300);
    #1;
    check("t5_resume_valid", 64'(imem_req_valid), 1);
    check("t5_resume_addr", imem_req_addr, 64'h300);
`else
    #1;
    check("t5_req_valid", 64'(imem_req_valid), 1);
    check("t5_aligned_addr", imem_req_addr, 64'h100);
    repeat (6) tick();
    check("t5_first_pc", lpc[0], 64'h100);
    check("t5_first_mis", 64'(lmis[0]), 0);
`endif

    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("t6_req_valid", 64'(imem_req_valid), 0);
    check("t6_instr_valid", 64'(instr_valid), 0);
    check("t6_instr_data", 64'(instr_data), 0);
    check("t6_instr_pc", instr_pc, 0);
    check("t6_misalign", 64'(instr_misalign), 0);
    rst = 1'b0;
    #1;
    check("t6_restart_valid", 64'(imem_req_valid), 1);
    check("t6_restart_addr", imem_req_addr, 0);
    clear_log();
    repeat (8) tick();
    check("t6_first_pc", lpc[0], 0);
    check("t6_first_data", 64'(ldat[0]), 64'hC0DE0000);
    check("t6_second_pc", lpc[1], 64'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
